wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback stage that owns the register file's single write port (reg_write / addr / write_reg).
- Merges two result sources:
  - the single-cycle ALU path, which has priority;
  - the multi-cycle slow path (load/mul/div), which is buffered in a small FIFO.
- Maintains a busy scoreboard of registers with slow results still outstanding, so issue logic can stall RAW/WAW hazards.
- Prevents slow-path starvation by inserting ALU stall cycles.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers, x0 hardwired zero)
- FIFO_DEPTH, 4, slow-path queue entries; power of two, >= 2
- STARVE_MAX, 4, consecutive ALU wins allowed while the queue is non-empty

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_stall  out  1  registered; when 1, ALU input is ignored and upstream must hold alu_*
- slow_valid  in  1  slow-path result offered
- slow_ready  out  1  queue can accept (= !full)
- slow_rd  in  ADDR_W  slow-path destination register
- slow_data  in  DATA_W  slow-path result
- iss_valid  in  1  a slow-path op is being issued this cycle
- iss_rd  in  ADDR_W  destination of the issued slow op
- busy  out  32  scoreboard; bit i = register i has a pending slow write
- reg_write  out  1  register-file write enable (registered)
- addr  out  ADDR_W  register-file write index (registered)
- write_reg  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, rst=1): reg_write=0, addr=0, write_reg=0, alu_stall=0, busy=0, queue empty (slow_ready=1 once rst deasserts), starve count=0.
- Enqueue:
  - A slow transfer occurs on an edge with slow_valid && slow_ready; the entry is {slow_rd, slow_data}.
  - Entries with slow_rd=0 are accepted but not stored (discarded).
  - slow_ready depends only on the registered occupancy: there is no enqueue into a full queue, even if a pop happens that cycle.
- Selection, each cycle:
  - if alu_valid && !alu_stall: the ALU wins;
  - else if the queue is non-empty: the queue head wins and is popped;
  - else: no write.
- An ALU result with alu_rd=0 wins the slot but produces reg_write=0.
- Output latency:
  - The selected result is registered into reg_write/addr/write_reg at the next edge.
  - ALU: valid at cycle N -> reg_write=1 in cycle N+1, for exactly one cycle per result.
  - Slow: enqueued at edge of cycle N -> earliest reg_write in cycle N+2.
- Starvation control:
  - The counter increments on each cycle where the ALU wins while the queue is non-empty.
  - It resets to 0 when the queue head wins or the queue is empty.
  - When the ALU wins with count == STARVE_MAX-1, alu_stall=1 for exactly the next cycle and the count clears.
  - During that stall cycle the queue head wins.
- Scoreboard:
  - On iss_valid with iss_rd!=0, busy[iss_rd] is set at the edge.
  - busy[rd] clears at the edge on which a slow-sourced write to rd is committed, i.e. the edge ending the cycle where reg_write=1 for that entry.
  - If set and clear hit the same rd on the same edge, set wins.
  - busy[0] is always 0.
  - ALU writes never touch busy. Upstream guarantees no ALU write targets a busy rd.
- FIFO:
  - Circular with wrap-around pointers of log2(FIFO_DEPTH)+1 bits.
  - full/empty are derived from the pointers.
  - Simultaneous push and pop on a non-full queue keeps occupancy unchanged.
- Reset mid-operation: all queued entries and busy bits are lost. An in-flight reg_write drops to 0 immediately (asynchronously).

Decomposition:
- Package wb_pkg holds:
  - DATA_W, ADDR_W, REG_COUNT=32;
  - wb_entry_t {rd, data};
  - SRC_NONE/SRC_ALU/SRC_SLOW encoding for the registered source tag used for the busy clear.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty and async active-high reset. The arbiter, starvation counter and scoreboard live in the top module.

Test Plan:
- ALU-only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1: reg_write=1, addr=5, write_reg=0xDEADBEEF. Cycle 2: reg_write=0 if alu_valid was dropped.
- Slow with scoreboard:
  - Stimulus: iss rd=7 at cycle 0; slow push rd=7, data=0x1234 at cycle 3 with ALU idle.
  - Response: busy[7]=1 from cycle 1; reg_write addr=7 data=0x1234 in cycle 5; busy[7]=0 from cycle 6.
- Starvation (STARVE_MAX=4):
  - Stimulus: queue holds 1 entry; alu_valid=1 continuously.
  - Response: 4 ALU writes, then alu_stall=1 for one cycle, the queue entry is written in that cycle, then ALU writes resume.
- Full queue: ALU continuously valid, STARVE_MAX raised above 8, push 4 entries -> slow_ready=0 after the 4th; a 5th slow_valid is not accepted until a pop. Entries then drain in FIFO order with correct wrap-around over 8+ total pushes.
- x0 handling:
  - ALU rd=0 -> no reg_write.
  - Slow push rd=0 -> handshake completes, no write.
  - iss_rd=0 -> busy stays 0.
- Async reset: assert rst mid-cycle with 3 queued entries and busy=0x00000080 -> busy=0, reg_write=0, slow_ready=1 after release, and no stale writes afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter.
// Entry layout and source tags used by the scoreboard clear path.
package wb_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_SLOW = 2'd2
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of writeback entries for the slow path.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic              do_push;
  logic              do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW-1] != rp_q[PW-1]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + PW'(1);
    if (do_pop)  rp_d = rp_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: ALU/slow-path merge onto the single RF write port,
// slow-path anti-starvation stall and pending-write scoreboard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_stall,
  input  logic                 slow_valid,
  output logic                 slow_ready,
  input  logic [ADDR_W-1:0]    slow_rd,
  input  logic [DATA_W-1:0]    slow_data,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_rd,
  output logic [REG_COUNT-1:0] busy,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    write_reg
);

  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  logic                 fifo_full, fifo_empty;
  logic                 push, pop, alu_win;
  wb_entry_t            head, din;

  logic                 rw_q, rw_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  src_e                 src_q, src_d;
  logic                 stall_q, stall_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;

  // x0 results complete the handshake but never occupy a slot
  assign slow_ready = !fifo_full;
  assign push       = slow_valid && !fifo_full && (slow_rd != '0);
  assign din        = '{rd: slow_rd, data: slow_data};
  assign alu_win    = alu_valid && !stall_q;
  assign pop        = !alu_win && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rw_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    src_d   = SRC_NONE;
    cnt_d   = '0;
    stall_d = 1'b0;
    if (alu_win) begin
      rw_d   = (alu_rd != '0);
      addr_d = alu_rd;
      data_d = alu_data;
      src_d  = SRC_ALU;
      if (!fifo_empty) begin
        if (cnt_q == CW'(STARVE_MAX - 1)) stall_d = 1'b1;
        else                              cnt_d   = cnt_q + CW'(1);
      end
    end else if (!fifo_empty) begin
      rw_d   = 1'b1;
      addr_d = head.rd;
      data_d = head.data;
      src_d  = SRC_SLOW;
    end
  end

  // clear before set so a same-edge reissue keeps the bit
  always_comb begin
    busy_d = busy_q;
    if (rw_q && src_q == SRC_SLOW) busy_d[addr_q] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= SRC_NONE;
      stall_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_write = rw_q;
  assign addr      = addr_q;
  assign write_reg = data_q;
  assign alu_stall = stall_q;
  assign busy      = busy_q;

endmodule
